// File: rtl/mem_arbiter.sv
// Multi-port memory arbiter. One write and up to four reads are collected in
// one IDLE cycle and then served one per cycle on a single-port RAM. The
// control unit is stalled until all results are in the rdataN registers.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memWE,
  input  logic [AW-1:0] memWAddr,
  input  logic [DW-1:0] memWData,
  input  logic          mem1RE,
  input  logic          mem2RE,
  input  logic          mem3RE,
  input  logic          mem4RE,
  input  logic [AW-1:0] mem1Addr,
  input  logic [AW-1:0] mem2Addr,
  input  logic [AW-1:0] mem3Addr,
  input  logic [AW-1:0] mem4Addr,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] rdata3,
  output logic [DW-1:0] rdata4,
  output logic          stall,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   stallCount
);

  typedef enum logic [1:0] {IDLE, SERVE, DRAIN, DONE} state_e;

  // Slot 0 is the write, slots 1..4 are reads 1..4; lower slot wins.
  logic [4:0]             req;
  state_e                 state_q, state_d;
  logic [4:0]             pend_q, pend_d;
  logic [4:0]             issue;
  logic [4:0][AW-1:0]     addr_q;
  logic [DW-1:0]          wdata_q;
  logic [3:0]             rsel_q, rsel_d;
  logic [3:0][DW-1:0]     rdata_q;
  logic [15:0]            cnt_q, cnt_d;
  logic                   hit;

  assign req = {mem4RE, mem3RE, mem2RE, mem1RE, memWE};

  // Next state, priority issue and RAM drive; stall never looks at ram_rdata.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    issue     = '0;
    hit       = 1'b0;
    stall     = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          stall   = 1'b1;
          pend_d  = req;
          state_d = SERVE;
        end
      end
      SERVE: begin
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
          if (pend_q[i] && !hit) begin
            hit      = 1'b1;
            issue[i] = 1'b1;
            ram_addr = addr_q[i];
          end
        end
        ram_we    = issue[0];
        ram_wdata = issue[0] ? wdata_q : '0;
        pend_d    = pend_q & ~issue;
        if (pend_d == '0) state_d = DRAIN;
      end
      DRAIN:   begin
        stall   = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    rsel_d = issue[4:1];
    cnt_d  = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  // FSM, pending bits, read-in-flight marker and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      rsel_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rsel_q  <= rsel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Addresses and write data are captured once per set; SERVE uses only these.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && |req) begin
      addr_q  <= {mem4Addr, mem3Addr, mem2Addr, mem1Addr, memWAddr};
      wdata_q <= memWData;
    end
  end

  // RAM data arrives one cycle after issue; capture into the matching result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (rsel_q[n]) rdata_q[n] <= ram_rdata;
    end
  end

  assign rdata1     = rdata_q[0];
  assign rdata2     = rdata_q[1];
  assign rdata3     = rdata_q[2];
  assign rdata4     = rdata_q[3];
  assign stallCount = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          memWE;
  logic [AW-1:0] memWAddr;
  logic [DW-1:0] memWData;
  logic          mem1RE, mem2RE, mem3RE, mem4RE;
  logic [AW-1:0] mem1Addr, mem2Addr, mem3Addr, mem4Addr;
  logic [DW-1:0] rdata1, rdata2, rdata3, rdata4;
  logic          stall;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [15:0]   stallCount;

  // RAM model with a preload port used while the arbiter is held in reset.
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] ram [256];

  // Reference state: memory image, expected results, expected stall count.
  logic [DW-1:0]      ref_mem [256];
  logic [3:0][DW-1:0] exp_rd;
  int                 exp_cnt;
  int                 n_chk = 0;
  int                 n_pass = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .memWE(memWE), .memWAddr(memWAddr), .memWData(memWData),
    .mem1RE(mem1RE), .mem2RE(mem2RE), .mem3RE(mem3RE), .mem4RE(mem4RE),
    .mem1Addr(mem1Addr), .mem2Addr(mem2Addr), .mem3Addr(mem3Addr), .mem4Addr(mem4Addr),
    .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4),
    .stall(stall), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic clear_in();
    memWE = 0; memWAddr = '0; memWData = '0;
    {mem4RE, mem3RE, mem2RE, mem1RE} = '0;
    {mem4Addr, mem3Addr, mem2Addr, mem1Addr} = '0;
  endtask

  task automatic scramble_in();
    memWE = 1'($urandom); memWAddr = AW'($urandom); memWData = DW'($urandom);
    {mem4RE, mem3RE, mem2RE, mem1RE} = 4'($urandom);
    {mem4Addr, mem3Addr, mem2Addr, mem1Addr} = 32'($urandom);
  endtask

  task automatic chk_results();
    chk("rdata1", rdata1, exp_rd[0]);
    chk("rdata2", rdata2, exp_rd[1]);
    chk("rdata3", rdata3, exp_rd[2]);
    chk("rdata4", rdata4, exp_rd[3]);
    chk("stallCount", stallCount, exp_cnt);
  endtask

  // Present one request set in IDLE and follow it to its DONE cycle.
  // Entered and left just after a rising edge with the arbiter in IDLE.
  task automatic run_set(input logic we, input logic [3:0] re, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [3:0][AW-1:0] ra);
    int k, n, exp_len;
    logic [AW-1:0] order [$];
    memWE = we; memWAddr = wa; memWData = wd;
    {mem4RE, mem3RE, mem2RE, mem1RE} = re;
    mem1Addr = ra[0]; mem2Addr = ra[1]; mem3Addr = ra[2]; mem4Addr = ra[3];
    k = int'(we) + $countones(re);
    // Write goes first, so reads in the same set see it.
    if (we) begin ref_mem[wa] = wd; order.push_back(wa); end
    for (int i = 0; i < 4; i++)
      if (re[i]) begin exp_rd[i] = ref_mem[ra[i]]; order.push_back(ra[i]); end
    exp_len = (k == 0) ? 0 : k + 2;
    if (k > 0) exp_cnt = (exp_cnt + exp_len > 65535) ? 65535 : exp_cnt + exp_len;
    n = 0;
    @(negedge clk);
    while (stall && n < 24) begin
      chk("ram_we", ram_we, (we && n == 1));
      if (n >= 1 && n <= k) chk("issue_addr", ram_addr, order[n-1]);
      if (ram_we) chk("ram_wdata", ram_wdata, wd);
      n++;
      @(posedge clk); #1 scramble_in();
      @(negedge clk);
    end
    chk("stall_len", n, exp_len);
    chk("done_ram_we", ram_we, 0);
    chk_results();
    @(posedge clk); #1 clear_in();
  endtask

  task automatic rand_set(input bit small_addr);
    logic [3:0][AW-1:0] ra;
    logic [AW-1:0] wa;
    wa = small_addr ? AW'($urandom_range(0, 7)) : AW'($urandom);
    for (int i = 0; i < 4; i++) ra[i] = small_addr ? AW'($urandom_range(0, 7)) : AW'($urandom);
    run_set(1'($urandom), 4'($urandom), wa, DW'($urandom), ra);
  endtask

  initial begin
    rst = 0; pl_en = 1; pl_addr = '0; pl_data = '0;
    clear_in();
    exp_rd = '0; exp_cnt = 0;
    for (int a = 0; a < 256; a++) begin
      pl_addr = AW'(a);
      pl_data = (a == 16) ? 16'hBEEF : DW'($urandom);
      ref_mem[a] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 0;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk_results();
    rst = 1;
    @(posedge clk); #1;

    // Single read of a preloaded word.
    run_set(0, 4'b0001, '0, '0, {8'h00, 8'h00, 8'h00, 8'h10});
    chk("beef", rdata1, 16'hBEEF);
    chk("beef_cnt", stallCount, 3);

    // Write plus all four reads.
    run_set(1, 4'b1111, 8'h40, 16'hA5A5, {8'h04, 8'h03, 8'h02, 8'h01});

    // Read-after-write in one set.
    run_set(1, 4'b0010, 8'h20, 16'h1234, {8'h00, 8'h00, 8'h20, 8'h00});
    chk("raw", rdata2, 16'h1234);

    // Quiet period.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_stall", stall, 0);
      chk("idle_we", ram_we, 0);
      @(posedge clk); #1;
    end
    chk("idle_cnt", stallCount, exp_cnt);

    // Reset during the second SERVE cycle of a four-read set.
    memWE = 0; {mem4RE, mem3RE, mem2RE, mem1RE} = 4'hF;
    {mem4Addr, mem3Addr, mem2Addr, mem1Addr} = {8'h13, 8'h12, 8'h11, 8'h10};
    @(posedge clk); @(posedge clk); #1;
    rst = 0; clear_in(); exp_rd = '0; exp_cnt = 0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_we", ram_we, 0);
    chk_results();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_hold_we", ram_we, 0);
    end
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_stall", stall, 0);
    chk_results();
    @(posedge clk); #1;

    // Random sets, half of them on a small address range to force overlaps.
    for (int s = 0; s < 300; s++) rand_set(s[0]);

    // Drive the counter to 16'hFFFE, then across saturation.
    while (exp_cnt + 7 <= 65534) rand_set(1'b0);
    while (exp_cnt + 3 <= 65534) run_set(0, 4'b0001, '0, '0, {4{AW'($urandom)}});
    run_set(0, 4'b0100, '0, '0, {4{AW'($urandom)}});
    chk("sat", stallCount, 16'hFFFF);
    run_set(0, 4'b1000, '0, '0, {4{AW'($urandom)}});
    chk("sat_hold", stallCount, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, as the data memory address width.
REQ-002 The block SHALL have parameter DW, default 16, as the data word width.
REQ-003 The block SHALL have port clk, input, 1, as the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, as the asynchronous active-low reset (asserted at 0).
REQ-005 The block SHALL have port memWE, input, 1, as the write request from the control unit.
REQ-006 The block SHALL have ports memWAddr (input, AW) and memWData (input, DW) as the write address and data.
REQ-007 The block SHALL have ports mem1RE..mem4RE, input, 1 each, as read requests 1-4.
REQ-008 The block SHALL have ports mem1Addr..mem4Addr, input, AW each, as the read addresses 1-4.
REQ-009 The block SHALL have ports rdata1..rdata4, output, DW each, as registered read results 1-4.
REQ-010 The block SHALL have port stall, output, 1, as the pipeline hold to the control unit.
REQ-011 The block SHALL have ports ram_addr (output, AW), ram_we (output, 1) and ram_wdata (output, DW) to the single-port RAM.
REQ-012 The block SHALL have port ram_rdata, input, DW, as RAM read data valid in the cycle after the address is issued.
REQ-013 The block SHALL have port stallCount, output, 16, as the saturating count of stalled cycles.

Function
REQ-014 The block SHALL implement the FSM IDLE, SERVE, DRAIN and DONE.
REQ-015 In IDLE with any request high, the block SHALL latch the request vector {memWE, mem1RE..mem4RE}, all addresses and memWData into pending registers, and go to SERVE.
REQ-016 In IDLE with no request high, the block SHALL remain in IDLE.
REQ-017 In SERVE, each cycle, the block SHALL issue exactly one pending request to the RAM in fixed priority (write, read1, read2, read3, read4) and clear its pending bit.
REQ-018 When the last pending bit is cleared, the block SHALL go from SERVE to DRAIN.
REQ-019 The block SHALL go from DRAIN to DONE, and from DONE to IDLE, unconditionally.
REQ-020 The block SHALL drive ram_we high only in the SERVE cycle issuing the write, and SHALL drive ram_addr/ram_wdata from the pending registers.
REQ-021 The block SHALL capture ram_rdata into rdataN at the end of the cycle following the issue of read N.
REQ-022 rdataN SHALL hold its value until read N is served again.
REQ-023 stall SHALL be combinational: 1 when (IDLE and any request) or SERVE or DRAIN, and 0 otherwise.
REQ-024 stall SHALL NOT depend combinationally on ram_rdata.
REQ-025 A set of k requests SHALL hold stall high for exactly k+2 cycles, followed by one DONE cycle with stall=0 and all rdataN valid.
REQ-026 Requests present during DONE SHALL be ignored, because they are the set just served while the control unit advances.
REQ-027 Because the write is served first, a read to memWAddr in the same set SHALL return memWData (read-after-write).
REQ-028 Inputs SHALL be ignored outside IDLE; the pending registers are the only source.
REQ-029 stallCount SHALL increment by 1 each cycle stall=1 and saturate at 16'hFFFF.

Reset
REQ-030 rst=0 SHALL force IDLE, clear all pending bits, and set rdata1..rdata4=0 and stallCount=0 immediately.
REQ-031 Under reset the block SHALL drive ram_we=0, ram_addr=0, ram_wdata=0, and stall SHALL be 0 once in IDLE with no requests.
REQ-032 Reset asserted mid-SERVE SHALL abandon outstanding requests with no further RAM write.
REQ-033 Operation SHALL resume on the first clk rising edge after rst returns to 1.

Verification
REQ-034 Single read: mem1RE=1, mem1Addr=8'h10, RAM[10]=16'hBEEF -> stall=1 for 3 cycles, then rdata1=16'hBEEF in DONE, stallCount=3.
REQ-035 Full set: memWE + 4 reads at addresses 1-4 -> ram_we in 1st SERVE cycle, reads issued in order 1-4, stall=1 for 7 cycles.
REQ-036 RAW: memWE, memWAddr=8'h20, memWData=16'h1234, mem2RE, mem2Addr=8'h20 -> rdata2=16'h1234.
REQ-037 Idle: no requests for 10 cycles -> stall=0, ram_we=0, stallCount unchanged.
REQ-038 Reset mid-op: rst=0 during the 2nd SERVE cycle of a 4-read set -> state IDLE, stall=0, rdata*=0, no ram_we.
REQ-039 Saturation: preload stallCount to 16'hFFFE and run a 1-read set -> stallCount=16'hFFFF and held.
